gcd_stream: RTL and testbench

//  Parametrised binary (Stein) GCD engine with valid/ready handshakes on input and output.

---
 rtl/gcd_stream.sv | 146 ++++++++++++++
 tb/tb_gcd_stream.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_stream.sv
// gcd_stream: binary (Stein) GCD engine with valid/ready handshakes.
//
// The engine accepts an unsigned operand pair in IDLE and runs one step per
// clock in CALC. It then presents the result in DONE until the consumer takes
// it. Besides the GCD it reports how many CALC cycles were used, counting the
// terminal cycle. It also flags the degenerate 0/0 case.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   operand pair valid
//   in_ready   out  engine idle and able to accept operands
//   ia, ib     in   operands (WIDTH bits, unsigned)
//   abort      in   cancel the computation in flight (only honoured in CALC)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer accepts the result
//   gcd        out  result (WIDTH bits)
//   cycles     out  CALC cycles used for this result (CNT_W bits)
//   zero_err   out  both operands were zero (gcd reported as 0)
module gcd_stream #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(2*WIDTH+2),
  localparam int K_W   = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ia,
  input  logic [WIDTH-1:0] ib,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd,
  output logic [CNT_W-1:0] cycles,
  output logic             zero_err
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [K_W-1:0]   r_k;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_gcd;
  logic [CNT_W-1:0] r_cycles;
  logic             r_zero_err;

  logic [CNT_W-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_a_shl;
  logic [WIDTH-1:0] w_b_shl;
  logic [WIDTH-1:0] w_diff_ab;
  logic [WIDTH-1:0] w_diff_ba;
  logic             w_a_zero;
  logic             w_b_zero;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // The shared power of two never pushes the result past the original
  // operand width, so these shifts lose nothing.
  assign w_a_shl   = r_a << r_k;
  assign w_b_shl   = r_b << r_k;
  // Each difference is only used when the compare says it cannot underflow.
  assign w_diff_ab = r_a - r_b;
  assign w_diff_ba = r_b - r_a;
  assign w_a_zero  = (r_a == '0);
  assign w_b_zero  = (r_b == '0);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign gcd       = r_gcd;
  assign cycles    = r_cycles;
  assign zero_err  = r_zero_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)                 w_next_state = CALC;
      // abort takes precedence over the terminal step
      CALC:    if (abort)                    w_next_state = IDLE;
               else if (w_a_zero || w_b_zero) w_next_state = DONE;
      DONE:    if (out_ready)                w_next_state = IDLE;
      default:                               w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_k        <= '0;
      r_cnt      <= '0;
      r_gcd      <= '0;
      r_cycles   <= '0;
      r_zero_err <= 1'b0;
    end else begin
      case (r_state)
        // operand capture
        IDLE: begin
          if (in_valid) begin
            r_a   <= ia;
            r_b   <= ib;
            r_k   <= '0;
            r_cnt <= '0;
          end
        end
        // one Stein step per clock
        CALC: begin
          if (!abort) begin
            r_cnt <= w_cnt_inc;
            if (w_a_zero) begin
              r_gcd      <= w_b_shl;
              r_zero_err <= w_b_zero;
              r_cycles   <= w_cnt_inc;
            end else if (w_b_zero) begin
              r_gcd      <= w_a_shl;
              r_zero_err <= 1'b0;
              r_cycles   <= w_cnt_inc;
            end else if (!r_a[0] && !r_b[0]) begin
              r_a <= r_a >> 1;
              r_b <= r_b >> 1;
              r_k <= r_k + K_W'(1);
            end else if (!r_a[0]) begin
              r_a <= r_a >> 1;
            end else if (!r_b[0]) begin
              r_b <= r_b >> 1;
            end else if (r_a >= r_b) begin
              r_a <= w_diff_ab >> 1;
            end else begin
              r_b <= w_diff_ba >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_stream.sv
// Directed plus random bench for gcd_stream (WIDTH=16). Expected results are
// queued when operands are accepted and compared when the engine delivers.
module tb_gcd_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ia;
  logic [15:0] ib;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] gcd;
  logic [5:0]  cycles;
  logic        zero_err;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [15:0] g;
    logic [5:0]  c;
    logic        z;
  } exp_t;

  exp_t sb[$];

  gcd_stream #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ia        (ia),
    .ib        (ib),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd       (gcd),
    .cycles    (cycles),
    .zero_err  (zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Euclid, independent of the engine's algorithm
  function automatic logic [15:0] euclid(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Step-rule cycle count model
  function automatic int model_cycles(input logic [15:0] a0, input logic [15:0] b0);
    logic [15:0] a, b;
    int n;
    a = a0; b = b0; n = 0;
    for (int i = 0; i < 100; i++) begin
      n++;
      if (a == 0 || b == 0) break;
      if (!a[0] && !b[0])  begin a = a >> 1; b = b >> 1; end
      else if (!a[0])      a = a >> 1;
      else if (!b[0])      b = b >> 1;
      else if (a >= b)     a = (a - b) >> 1;
      else                 b = (b - a) >> 1;
    end
    return n;
  endfunction

  task automatic accept(input logic [15:0] a, input logic [15:0] b);
    int   n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    ia = a;
    ib = b;
    e.g = euclid(a, b);
    e.c = 6'(model_cycles(a, b));
    e.z = (a == 0) && (b == 0);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    // scramble operands: the computation in flight must not see this
    ia = 16'($urandom);
    ib = 16'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op(input int hold, input logic abort_in_done);
    int   lat;
    exp_t e;
    wait_valid(lat);
    chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("latency",  lat,      {26'd0, e.c});
      chk("gcd",      gcd,      {16'd0, e.g});
      chk("cycles",   cycles,   {26'd0, e.c});
      chk("zero_err", zero_err, {31'd0, e.z});
      chk("cyc_bound", {31'd0, cycles <= 6'd33}, 32'd1);
      abort = abort_in_done;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_gcd",   gcd,                {16'd0, e.g});
        chk("hold_ready", {31'd0, in_ready},  32'd0);
      end
      abort = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("drop_valid", {31'd0, out_valid}, 32'd0);
      chk("ready_back", {31'd0, in_ready},  32'd1);
      chk("gcd_kept",   gcd,                {16'd0, e.g});
    end
  endtask

  initial begin
    int lat;
    logic [15:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; ia = '0; ib = '0; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_gcd",       gcd,                32'd0);
    chk("rst_cycles",    cycles,             32'd0);
    chk("rst_zero_err",  {31'd0, zero_err},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1
    accept(16'd48, 16'd18);
    finish_op(0, 1'b0);
    chk("T1_gcd_abs",    gcd,    32'd6);
    chk("T1_cycles_abs", cycles, 32'd7);

    // T2
    accept(16'hFFFF, 16'd0);
    finish_op(0, 1'b0);
    chk("T2_gcd_abs", gcd, 32'hFFFF);
    chk("T2_cyc_abs", cycles, 32'd1);
    accept(16'd0, 16'd0);
    finish_op(0, 1'b0);
    chk("T2_zero_abs", {31'd0, zero_err}, 32'd1);
    chk("T2_zgcd_abs", gcd, 32'd0);

    // T3
    accept(16'd1, 16'hFFFF);
    finish_op(0, 1'b0);
    chk("T3_gcd_abs", gcd, 32'd1);
    for (int i = 0; i < 800; i++) begin
      ra = 16'($urandom) >> $urandom_range(0, 15);
      rb = 16'($urandom) >> $urandom_range(0, 15);
      if (i % 7 == 0) ra = ra << $urandom_range(0, 4);
      accept(ra, rb);
      finish_op(0, 1'b0);
    end

    // T4: backpressure, with abort asserted while DONE (must be ignored)
    accept(16'd12, 16'd8);
    finish_op(5, 1'b1);
    chk("T4_gcd_abs", gcd, 32'd4);

    // T5: abort on the third CALC cycle
    accept(16'd48, 16'd18);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sb.delete();
    chk("T5_idle",      {31'd0, in_ready},  32'd1);
    chk("T5_no_valid",  {31'd0, out_valid}, 32'd0);
    chk("T5_gcd_kept",  gcd,                32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("T5_never_valid", {31'd0, out_valid}, 32'd0);
    end
    accept(16'd35, 16'd21);
    finish_op(0, 1'b0);
    chk("T5_gcd_abs", gcd, 32'd7);

    // T6: asynchronous reset during CALC, then during DONE
    accept(16'd48, 16'd18);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("T6c_in_ready",  {31'd0, in_ready},  32'd1);
    chk("T6c_out_valid", {31'd0, out_valid}, 32'd0);
    chk("T6c_gcd",       gcd,                32'd0);
    chk("T6c_cycles",    cycles,             32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    accept(16'd12, 16'd8);
    wait_valid(lat);
    chk("T6d_valid", {31'd0, out_valid}, 32'd1);
    chk("T6d_gcd",   gcd,                32'd4);
    #2 rst = 1'b1;
    #1;
    chk("T6d_in_ready",  {31'd0, in_ready},  32'd1);
    chk("T6d_out_valid", {31'd0, out_valid}, 32'd0);
    chk("T6d_gcd_rst",   gcd,                32'd0);
    chk("T6d_cycles",    cycles,             32'd0);
    chk("T6d_zero_err",  {31'd0, zero_err},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    accept(16'd9, 16'd6);
    finish_op(0, 1'b0);
    chk("T6_gcd_abs", gcd, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
